// File: rtl/uart_frame_wc_if.sv
// Register-bus interface for the UART slot. The MMIO controller drives the
// request side (master) and the UART returns combinational read data (slave).
interface uart_frame_wc_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/uart_frame_wc.sv
// UART with programmable frame format (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits), 16-entry TX/RX FIFOs and sticky write-1-to-clear error
// flags. Defining UART_FRAME_WC_INTR_EN adds a registered irq output driven
// by ctrl[5]; without it ctrl[5] is storage only.

// Byte FIFO with an extra pointer bit to tell full from empty.
module uart_frame_wc_fifo #(
  parameter int DEPTH_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  logic [7:0]         mem [2**DEPTH_BIT];
  logic [DEPTH_BIT:0] wptr, rptr;
  logic               push_ok, pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[DEPTH_BIT] != rptr[DEPTH_BIT]) &&
                   (wptr[DEPTH_BIT-1:0] == rptr[DEPTH_BIT-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr[DEPTH_BIT-1:0]];

  // Pointer update; wrap is implicit in the modulo-2^(DEPTH_BIT+1) counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is plain data and needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[DEPTH_BIT-1:0]] <= wdata;
  end
endmodule

module uart_frame_wc #(
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int OVERSAMPLE     = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_frame_wc_if.slave bus,
  output logic           tx,
  input  logic           rx
`ifdef UART_FRAME_WC_INTR_EN
  ,
  output logic           irq
`endif
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [10:0] dvsr, baud_dvsr, baud_cnt;
  logic [5:0]  ctrl;
  logic [2:0]  err_flags;        // {ovr, frm, par}
  logic        wr_en, tick;
  logic [2:0]  w1c;
  logic        tx_push, rx_pop;
  logic        rx_sync_p0, rx_sync_p1;

  state_t      tx_state, tx_state_nxt;
  logic [TW-1:0] tx_tick_cnt;
  logic [2:0]  tx_bit_cnt;
  logic [4:0]  tx_ctrl;
  logic [7:0]  tx_shreg, tx_head;
  logic        tx_par, tx_start, tx_bit_end, tx_last_bit, tx_empty, tx_full, tx_idle;

  state_t      rx_state, rx_state_nxt;
  logic [TW-1:0] rx_tick_cnt;
  logic [2:0]  rx_bit_cnt;
  logic [3:0]  rx_ctrl;
  logic [7:0]  rx_shreg, rx_byte, rx_head;
  logic        rx_s, rx_par, rx_par_bad, rx_bit_end, rx_half_end, rx_last_bit;
  logic        rx_push, rx_empty, rx_full, frm_set, par_set, ovr_set;
  logic        unused_bits;

  assign wr_en   = bus.cs && bus.write;
  assign tx_push = wr_en && (bus.addr[2:0] == 3'd2);
  assign rx_pop  = wr_en && (bus.addr[2:0] == 3'd3);
  assign w1c     = (wr_en && (bus.addr[2:0] == 3'd5)) ? bus.wr_data[2:0] : 3'b000;
  assign tick    = (baud_cnt >= baud_dvsr);
  assign tx_idle = (tx_state == S_IDLE) && tx_empty;
  assign rx_s    = rx_sync_p1;

  // Configuration registers written from the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr <= '0;
      ctrl <= 6'b000011;
    end else if (wr_en) begin
      if (bus.addr[2:0] == 3'd1) dvsr <= bus.wr_data[10:0];
      if (bus.addr[2:0] == 3'd4) ctrl <= bus.wr_data[5:0];
    end
  end

  // Baud generator; the divisor only follows dvsr while no frame is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      baud_dvsr <= '0;
    end else begin
      if (tx_state == S_IDLE && rx_state == S_IDLE) baud_dvsr <= dvsr;
      baud_cnt <= tick ? 11'd0 : baud_cnt + 11'd1;
    end
  end

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  uart_frame_wc_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_start),
    .wdata(bus.wr_data[7:0]), .rdata(tx_head), .empty(tx_empty), .full(tx_full));

  uart_frame_wc_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
    .wdata(rx_byte), .rdata(rx_head), .empty(rx_empty), .full(rx_full));

  // ---- transmitter ----
  // Frames start on a baud tick so every bit, the start bit included, is whole.
  assign tx_start    = (tx_state == S_IDLE) && !tx_empty && tick;
  assign tx_bit_end  = tick && (tx_tick_cnt == OS_LAST);
  assign tx_last_bit = (tx_bit_cnt == {1'b1, tx_ctrl[1:0]});

  // TX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  // TX next-state logic.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (tx_start) tx_state_nxt = S_START;
      S_START:  if (tx_bit_end) tx_state_nxt = S_DATA;
      S_DATA:   if (tx_bit_end && tx_last_bit)
                  tx_state_nxt = (tx_ctrl[3] ^ tx_ctrl[2]) ? S_PARITY : S_STOP;
      S_PARITY: if (tx_bit_end) tx_state_nxt = S_STOP;
      S_STOP:   if (tx_bit_end && (!tx_ctrl[4] || tx_bit_cnt[0])) tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  // TX line level; IDLE and STOP (and reset) hold the line high.
  always_comb begin
    tx = 1'b1;
    case (tx_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = tx_shreg[0];
      S_PARITY: tx = tx_par ^ tx_ctrl[3];
      default:  tx = 1'b1;
    endcase
  end

  // TX tick/bit counters and the frame format latched at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_ctrl     <= 5'b00011;
    end else if (tx_state == S_IDLE) begin
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      if (tx_start) tx_ctrl <= ctrl[4:0];
    end else if (tick) begin
      tx_tick_cnt <= tx_bit_end ? '0 : tx_tick_cnt + 1'b1;
      if (tx_bit_end && tx_state == S_DATA)
        tx_bit_cnt <= tx_last_bit ? 3'd0 : tx_bit_cnt + 3'd1;
      else if (tx_bit_end && tx_state == S_STOP)
        tx_bit_cnt <= tx_bit_cnt + 3'd1;
    end
  end

  // TX shift register and running data parity.
  always_ff @(posedge clk) begin
    if (tx_start) begin
      tx_shreg <= tx_head;
      tx_par   <= 1'b0;
    end else if (tx_state == S_DATA && tx_bit_end) begin
      tx_shreg <= tx_shreg >> 1;
      tx_par   <= tx_par ^ tx_shreg[0];
    end
  end

  // ---- receiver ----
  assign rx_bit_end  = tick && (rx_tick_cnt == OS_LAST);
  assign rx_half_end = tick && (rx_tick_cnt == OS_HALF);
  assign rx_last_bit = (rx_bit_cnt == {1'b1, rx_ctrl[1:0]});
  // Data arrives LSB first into the top, so shift down by 8 - width to right-align.
  assign rx_byte     = rx_shreg >> (~rx_ctrl[1:0]);

  // RX state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= S_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  // RX next-state logic; a start bit that is high again at mid-bit is a glitch.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (!rx_s) rx_state_nxt = S_START;
      S_START:  if (rx_half_end) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_bit_end && rx_last_bit)
                  rx_state_nxt = (rx_ctrl[3] ^ rx_ctrl[2]) ? S_PARITY : S_STOP;
      S_PARITY: if (rx_bit_end) rx_state_nxt = S_STOP;
      S_STOP:   if (rx_bit_end) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  // RX frame outcome at the stop-bit sample: push, framing, parity, overrun.
  always_comb begin
    rx_push = (rx_state == S_STOP) && rx_bit_end && rx_s;
    frm_set = (rx_state == S_STOP) && rx_bit_end && !rx_s;
    ovr_set = rx_push && rx_full && !rx_pop;
    par_set = rx_push && rx_par_bad && !ovr_set;
  end

  // RX tick/bit counters and the frame format latched at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_ctrl     <= 4'b0011;
    end else if (rx_state == S_IDLE) begin
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      if (!rx_s) rx_ctrl <= ctrl[3:0];
    end else if (tick) begin
      if (rx_state == S_START) rx_tick_cnt <= rx_half_end ? '0 : rx_tick_cnt + 1'b1;
      else                     rx_tick_cnt <= rx_bit_end ? '0 : rx_tick_cnt + 1'b1;
      if (rx_bit_end && rx_state == S_DATA)
        rx_bit_cnt <= rx_last_bit ? 3'd0 : rx_bit_cnt + 3'd1;
    end
  end

  // RX shift register, running parity and parity verdict.
  always_ff @(posedge clk) begin
    if (rx_state == S_IDLE) begin
      rx_par     <= 1'b0;
      rx_par_bad <= 1'b0;
    end else if (rx_bit_end && rx_state == S_DATA) begin
      rx_shreg <= {rx_s, rx_shreg[7:1]};
      rx_par   <= rx_par ^ rx_s;
    end else if (rx_bit_end && rx_state == S_PARITY) begin
      rx_par_bad <= (rx_s != (rx_par ^ rx_ctrl[3]));
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_flags <= '0;
    else       err_flags <= {ovr_set, frm_set, par_set} | (err_flags & ~w1c);
  end

  // Register read mux; reads have no side effects.
  always_comb begin
    bus.rd_data = '0;
    case (bus.addr[2:0])
      3'd0: bus.rd_data = {18'b0, err_flags, tx_idle, tx_full, rx_empty,
                           (rx_empty ? 8'h00 : rx_head)};
      3'd1: bus.rd_data = {21'b0, dvsr};
      3'd4: bus.rd_data = {26'b0, ctrl};
      default: bus.rd_data = '0;
    endcase
  end

`ifdef UART_FRAME_WC_INTR_EN
  // Registered interrupt request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= ctrl[5] && (!rx_empty || tx_idle || (|err_flags));
  end
  assign unused_bits = &{1'b0, bus.read, bus.addr[4:3], bus.wr_data[31:11]};
`else
  assign unused_bits = &{1'b0, bus.read, bus.addr[4:3], bus.wr_data[31:11], ctrl[5]};
`endif
endmodule
